// File: rtl/free_reg_list.sv
// ---------------------------------------------------------------------------
// free_reg_list
//
// Circular free list of physical register indices for one register class.
// Rename allocates destination registers from the head. Commit returns
// superseded registers at the tail. Branch checkpoints snapshot the head
// pointer, so a misprediction restore hands back every register allocated
// after the checkpoint in a single cycle.
//
// Ports:
//   clk, n_rst        clock; synchronous active-low reset
//   alloc_req         rename consumes alloc_addr this cycle
//   alloc_valid       a free register is available (count != 0)
//   alloc_addr        register at head (combinational read of the array)
//   return_en/addr    commit returns a register to the tail
//   ckpt_save/idx     snapshot head into a checkpoint slot
//   ckpt_restore/idx  roll head back to a checkpoint slot
//   free_count        number of free entries (registered)
//   overflow_err      sticky: return_en while the list was full
//   underflow_err     sticky: alloc_req while the list was empty
//
// Handshake: an allocation transfers on a clock edge where alloc_valid and
// alloc_req are both high. alloc_valid does not depend on alloc_req, and
// alloc_addr is stable for the whole cycle. alloc_req with alloc_valid low
// is dropped and flags underflow_err. A restore in the same cycle cancels
// the allocation without flagging an error.
// ---------------------------------------------------------------------------
module free_reg_list #(
   parameter  int NUM_PREG = 64,
   parameter  int NUM_LREG = 16,
   parameter  int NUM_CKPT = 4,
   localparam int DEPTH    = NUM_PREG - NUM_LREG,
   localparam int PW       = $clog2(NUM_PREG),
   localparam int HW       = $clog2(DEPTH),
   localparam int CW       = $clog2(NUM_CKPT)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          alloc_req,
   output logic          alloc_valid,
   output logic [PW-1:0] alloc_addr,
   input  logic          return_en,
   input  logic [PW-1:0] return_addr,
   input  logic          ckpt_save,
   input  logic [CW-1:0] ckpt_save_idx,
   input  logic          ckpt_restore,
   input  logic [CW-1:0] ckpt_restore_idx,
   output logic [HW:0]   free_count,
   output logic          overflow_err,
   output logic          underflow_err
);

   logic [PW-1:0] fl_mem    [DEPTH];
   logic [HW-1:0] ckpt_slot [NUM_CKPT];
   logic [HW-1:0] head;
   logic [HW-1:0] tail;
   logic [HW:0]   count;

   logic          is_empty;
   logic          is_full;
   logic          alloc_fire;
   logic          return_fire;
   logic          save_fire;
   logic [HW-1:0] restore_head;
   logic [HW:0]   rollback;
   logic [HW-1:0] head_nxt;
   logic [HW:0]   count_nxt;

   // DEPTH need not be a power of two, so wrap explicitly.
   function automatic logic [HW-1:0] ptr_inc(input logic [HW-1:0] p);
      return (p == HW'(DEPTH - 1)) ? '0 : p + HW'(1);
   endfunction

   // head == tail alone is ambiguous; fullness always comes from count.
   assign is_empty     = (count == '0);
   assign is_full      = (count == (HW+1)'(DEPTH));

   // A restore flushes the branch that would allocate or save this cycle.
   assign alloc_fire   = alloc_req & ~is_empty & ~ckpt_restore;
   assign return_fire  = return_en & ~is_full;
   assign save_fire    = ckpt_save & ~ckpt_restore;

   // Number of entries handed out since the checkpoint: (head - slot) mod
   // DEPTH, computed one bit wider so the non-wrapped form cannot overflow.
   assign restore_head = ckpt_slot[ckpt_restore_idx];
   assign rollback     = (head >= restore_head)
                       ? ({1'b0, head} - {1'b0, restore_head})
                       : ({1'b0, head} + (HW+1)'(DEPTH) - {1'b0, restore_head});

   always_comb begin
      head_nxt  = head;
      count_nxt = count;
      if (ckpt_restore) begin
         head_nxt  = restore_head;
         count_nxt = count + rollback + (HW+1)'(return_fire);
      end else begin
         if (alloc_fire) begin
            head_nxt = ptr_inc(head);
         end
         count_nxt = count + (HW+1)'(return_fire) - (HW+1)'(alloc_fire);
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            fl_mem[i] <= PW'(NUM_LREG + i);
         end
         for (int c = 0; c < NUM_CKPT; c++) begin
            ckpt_slot[c] <= '0;
         end
         head          <= '0;
         tail          <= '0;
         count         <= (HW+1)'(DEPTH);
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         head  <= head_nxt;
         count <= count_nxt;
         if (return_fire) begin
            fl_mem[tail] <= return_addr;
            tail         <= ptr_inc(tail);
         end
         // The saved head is the pre-increment value, so the branch's own
         // allocation is not rolled back.
         if (save_fire) begin
            ckpt_slot[ckpt_save_idx] <= head;
         end
         if (return_en && is_full) begin
            overflow_err <= 1'b1;
         end
         if (alloc_req && is_empty && !ckpt_restore) begin
            underflow_err <= 1'b1;
         end
      end
   end

   assign alloc_valid = ~is_empty;
   assign alloc_addr  = fl_mem[head];
   assign free_count  = count;

endmodule

// File: doc/free_reg_list.md
Name: free_reg_list

Overview:
- Circular free list of physical register indices, one instance per register class (D and S).
- Consumer end of the commit-return path: the reorder buffer returns superseded physical registers (return valid + address) on commit.
- Rename/decode allocates new destination registers from the head.
- Branch checkpoints snapshot the head pointer, so a misprediction restore un-allocates every register handed out after the checkpoint in one cycle.

Parameters:
NUM_PREG, 64, physical registers in this class
NUM_LREG, 16, architectural registers; physical 0..NUM_LREG-1 are mapped at reset
NUM_CKPT, 4, checkpoint slots
DEPTH, NUM_PREG-NUM_LREG (derived, not overridable), free-list capacity; need not be a power of two
PW, $clog2(NUM_PREG) (derived), physical address width
HW, $clog2(DEPTH) (derived), pointer width
CW, $clog2(NUM_CKPT) (derived), checkpoint index width

Ports:
clk  in  1  clock
n_rst  in  1  reset, synchronous, active-low
alloc_req  in  1  rename consumes alloc_addr this cycle
alloc_valid  out  1  free register available (count != 0)
alloc_addr  out  PW  register at head; combinational from array
return_en  in  1  commit returns a register
return_addr  in  PW  register being returned
ckpt_save  in  1  snapshot head into slot ckpt_save_idx
ckpt_save_idx  in  CW  slot written
ckpt_restore  in  1  misprediction recovery
ckpt_restore_idx  in  CW  slot read
free_count  out  HW+1  entries currently free
overflow_err  out  1  sticky: return_en while count==DEPTH
underflow_err  out  1  sticky: alloc_req while count==0

Behaviour:
- Storage:
  - array[DEPTH] of PW bits.
  - head and tail pointers, HW bits; all increments wrap modulo DEPTH explicitly (no power-of-two assumption).
  - count register, HW+1 bits.
- Reset (clk edge with n_rst=0):
  - array[i] = NUM_LREG+i; head=0; tail=0; count=DEPTH.
  - Every ckpt slot = 0; overflow_err=0; underflow_err=0.
  - Effect: alloc_valid=1, alloc_addr=NUM_LREG, free_count=DEPTH the cycle after reset.
  - Reset mid-operation discards all state identically.
- Allocation:
  - alloc_addr = array[head]; zero-latency read.
  - alloc_req & alloc_valid: head <= head+1 mod DEPTH; count decrements.
  - alloc_req with count==0: ignored; set underflow_err. No bypass from return_en in the same cycle.
- Return:
  - return_en: array[tail] <= return_addr; tail <= tail+1 mod DEPTH; count increments.
  - Returned entry is visible at alloc_addr no earlier than the next cycle.
  - return_en with count==DEPTH: write suppressed; set overflow_err.
- Checkpoint save:
  - ckpt_save: slot[ckpt_save_idx] <= head.
  - When alloc_req fires in the same cycle, the saved value is the pre-increment head (the branch's own allocation occurs after its checkpoint).
- Checkpoint restore:
  - ckpt_restore: head <= slot[ckpt_restore_idx].
  - count <= count + ((head - slot) mod DEPTH) + return_en.
  - The rolled-back entries are still intact in the array; tail never overtakes them because physical registers are conserved.
- Priority / simultaneous events:
  - restore beats alloc_req: alloc ignored, no underflow_err.
  - restore beats save: save ignored, because the saving branch is itself flushed.
  - restore with return_en: both take effect.
  - alloc + return in the same cycle: count unchanged, both pointers advance.
  - head==tail is ambiguous between full and empty; always disambiguate with count.
- free_count = count, registered.
- Errors clear only on reset.

Test Plan:
- Reset, then alloc_req for 48 consecutive cycles -> alloc_addr sequence 16..63; alloc_valid=0 and free_count=0 after the 48th; a 49th alloc_req sets underflow_err=1 and head is unchanged.
- From reset: alloc ×3 (16,17,18), then return_en with 5, 9 -> free_count 47; after 45 more allocs alloc_addr=5, then 9.
- Simultaneous alloc_req and return_en(7) with free_count=10 -> free_count stays 10; tail and head each advance by 1.
- Checkpoint: after 2 allocs, ckpt_save idx=1 (head=2); allocate 4 more (free_count=42); ckpt_restore idx=1 -> next cycle alloc_addr=18, free_count=46.
- Head wrap: reach head=46 with tail wrapped; save at head=46, allocate 5 (head=3); restore with return_en(20) in the same cycle -> head=46, count increases by 5+1.
- Same-cycle restore + alloc_req + ckpt_save -> only restore applies; save slot unchanged; no underflow_err; return_en at count==48 -> overflow_err=1 and array unchanged.
